// File: rtl/cbc_pkg.sv
// Shared types and the 4-bit block cipher for the CBC encryptor.
// E_k(x) rotates (x ^ k) left by one bit.
package cbc_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO,
        OUT
    } state_e;

    function automatic nibble_t cbc_enc(input nibble_t x, input nibble_t k);
        nibble_t t;
        t = x ^ k;
        return {t[2:0], t[3]};
    endfunction

endpackage

// File: rtl/nibble_cipher.sv
// Combinational single-nibble encryption under key k_i.
module nibble_cipher
    import cbc_pkg::*;
(
    input  logic [3:0] x_i,
    input  logic [3:0] k_i,
    output logic [3:0] y_o
);

    assign y_o = cbc_enc(x_i, k_i);

endmodule

// File: rtl/cbc_block_encryptor.sv
// CBC encryptor: chains plaintext nibbles with the previous ciphertext (IV first),
// encrypts them and packs pairs into 8-bit blocks; odd messages get a zero pad nibble.
module cbc_block_encryptor
    import cbc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key,
    input  logic [3:0] iv,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [7:0] blk_cnt
);

    state_e  state_q, state_d;
    nibble_t key_q, key_d;
    nibble_t chain_q, chain_d;
    nibble_t hi_q, hi_d;
    nibble_t lo_q, lo_d;
    logic    last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    nibble_t data_x;
    nibble_t data_ct;
    nibble_t pad_ct;
    logic    in_hs;

    assign data_x = in_data ^ chain_q;

    nibble_cipher u_data_cipher (
        .x_i (data_x),
        .k_i (key_q),
        .y_o (data_ct)
    );

    // The pad nibble is zero, so its chained input is just the fresh ciphertext.
    nibble_cipher u_pad_cipher (
        .x_i (data_ct),
        .k_i (key_q),
        .y_o (pad_ct)
    );

    // Both handshake flags decode registered state only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q == HI) || (state_q == LO);
    assign out_valid = (state_q == OUT);
    assign out_data  = {hi_q, lo_q};
    assign out_last  = last_q & out_valid;
    assign blk_cnt   = cnt_q;
    assign in_hs     = in_valid & in_ready;

    always_comb begin
        // NOTE: every next-state signal is defaulted to hold first, so no path can infer a latch.
        state_d = state_q;
        key_d   = key_q;
        chain_d = chain_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE, HI, LO: begin
                if (start) begin
                    key_d   = key;
                    chain_d = iv;
                    cnt_d   = '0;
                    hi_d    = '0;
                    last_d  = 1'b0;
                    state_d = HI;
                end else if (in_hs && state_q == HI) begin
                    hi_d    = data_ct;
                    chain_d = data_ct;
                    last_d  = in_last;
                    state_d = LO;
                    if (in_last) begin
                        lo_d    = pad_ct;
                        chain_d = pad_ct;
                        state_d = OUT;
                    end
                end else if (in_hs && state_q == LO) begin
                    lo_d    = data_ct;
                    chain_d = data_ct;
                    last_d  = in_last;
                    state_d = OUT;
                end
            end
            OUT: begin
                // start is ignored here: the block drains before anything else happens.
                if (out_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = last_q ? IDLE : HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            chain_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            chain_q <= chain_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cbc_block_encryptor.sv
// Randomised self-checking bench for cbc_block_encryptor against a message-level CBC model.
module tb_cbc_block_encryptor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key, iv, in_data;
    logic       start, in_valid, in_last, out_ready;
    logic       in_ready, out_valid, out_last;
    logic [7:0] out_data, blk_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cbc_block_encryptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .iv        (iv),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .blk_cnt   (blk_cnt)
    );

    function automatic int enc(input int x, input int k);
        int t;
        t = (x ^ k) & 15;
        return ((t * 2) + (t / 8)) & 15;
    endfunction

    // Whole-message reference: pad to even length, chain, encrypt, pair up.
    function automatic void model(input logic [3:0] k, input logic [3:0] v,
                                  input logic [3:0] msg[$], output logic [7:0] exp[$]);
        int p[$];
        int ch;
        int c0, c1;
        exp = {};
        foreach (msg[i]) p.push_back(int'(msg[i]));
        if (p.size() % 2 == 1) p.push_back(0);
        ch = int'(v);
        for (int i = 0; i < p.size(); i += 2) begin
            c0 = enc(p[i] ^ ch, int'(k));
            c1 = enc(p[i+1] ^ c0, int'(k));
            ch = c1;
            exp.push_back(8'(c0 * 16 + c1));
        end
    endfunction

    // Entered and left on a falling edge.
    task automatic pulse_start(input logic [3:0] k, input logic [3:0] v);
        start = 1'b1; key = k; iv = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds msg (optionally after a start pulse), accepting blocks with random stalls;
    // checks output stability under back-pressure and in_ready low during OUT.
    task automatic run_msg(input bit do_start, input logic [3:0] k, input logic [3:0] v,
                           input logic [3:0] msg[$], input int stall_pct,
                           output logic [7:0] blks[$], output logic lasts[$],
                           output logic [7:0] cnts[$], output bit timed_out);
        int idx = 0;
        int cyc = 0;
        bit done = 0;
        bit held = 0;
        logic [7:0] held_data;
        logic held_last;
        blks = {}; lasts = {}; cnts = {};
        if (do_start) pulse_start(k, v);
        while (!done && cyc < 5000) begin
            in_valid = 1'b0; out_ready = 1'b0;
            if (out_valid) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL in_ready_during_out: got %b want 0", in_ready);
                end
                if (held) begin
                    total++;
                    if (out_data !== held_data || out_last !== held_last) begin
                        bad++;
                        $display("FAIL stall_stable: got %h/%b want %h/%b",
                                 out_data, out_last, held_data, held_last);
                    end
                end
                if (32'($urandom_range(99)) >= stall_pct) begin
                    out_ready = 1'b1;
                    blks.push_back(out_data); lasts.push_back(out_last); cnts.push_back(blk_cnt);
                    held = 0;
                    if (out_last) done = 1;
                end else begin
                    held = 1; held_data = out_data; held_last = out_last;
                end
            end else if (in_ready && idx < msg.size() && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                in_data  = msg[idx];
                in_last  = (idx == msg.size() - 1);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
        timed_out = !done;
    endtask

    task automatic check_msg(input string name, input logic [3:0] k, input logic [3:0] v,
                             input logic [3:0] msg[$], input int stall_pct);
        logic [7:0] exp[$], blks[$], cnts[$];
        logic lasts[$];
        bit to;
        model(k, v, msg, exp);
        run_msg(1, k, v, msg, stall_pct, blks, lasts, cnts, to);
        total++;
        if (to || blks.size() != exp.size()) begin
            bad++;
            $display("FAIL %s_count: got %0d blocks (timeout=%0b) want %0d", name, blks.size(), to, exp.size());
        end else begin
            foreach (exp[i]) begin
                total++;
                if (blks[i] !== exp[i] || lasts[i] !== (i == exp.size() - 1) || cnts[i] !== 8'(i)) begin
                    bad++;
                    $display("FAIL %s_blk%0d: got %h last=%b cnt=%0d want %h last=%b cnt=%0d",
                             name, i, blks[i], lasts[i], cnts[i], exp[i], (i == exp.size() - 1), 8'(i));
                end
            end
        end
        total++;
        if (blk_cnt !== 8'(exp.size()) || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_end: got cnt=%0d in_ready=%b out_valid=%b want cnt=%0d 0 0",
                     name, blk_cnt, in_ready, out_valid, 8'(exp.size()));
        end
    endtask

    task automatic test_reset();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_last !== 1'b0 || blk_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h last=%b cnt=%0d want all 0",
                     in_ready, out_valid, out_data, out_last, blk_cnt);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] m1[$] = '{4'h3, 4'h5, 4'h0, 4'hF};
        logic [3:0] m2[$] = '{4'h3, 4'h5, 4'h0};
        logic [7:0] exp[$];
        // Known answers: 29,40 and 29,4F (zero pad).
        model(4'hB, 4'h9, m1, exp);
        total++;
        if (exp.size() != 2 || exp[0] !== 8'h29 || exp[1] !== 8'h40) begin
            bad++; $display("FAIL model_kat1: got %p want 29 40", exp);
        end
        model(4'hB, 4'h9, m2, exp);
        total++;
        if (exp.size() != 2 || exp[0] !== 8'h29 || exp[1] !== 8'h4F) begin
            bad++; $display("FAIL model_kat2: got %p want 29 4f", exp);
        end
        check_msg("kat_even", 4'hB, 4'h9, m1, 0);
        check_msg("kat_pad", 4'hB, 4'h9, m2, 0);
    endtask

    task automatic test_backpressure();
        int n = 0;
        pulse_start(4'hB, 4'h9);
        in_valid = 1'b1; in_last = 1'b0; in_data = 4'h3;
        @(negedge clk);
        in_data = 4'h5;
        @(negedge clk);
        // Offer a nibble throughout the stall; it must not be consumed.
        in_data = 4'hA;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h29 || out_last !== 1'b0 ||
                in_ready !== 1'b0 || blk_cnt !== 8'd0) begin
                bad++;
                $display("FAIL bp_hold%0d: got vld=%b data=%h last=%b rdy=%b cnt=%0d want 1 29 0 0 0",
                         i, out_valid, out_data, out_last, in_ready, blk_cnt);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_cnt !== 8'd1) begin
            bad++;
            $display("FAIL bp_release: got vld=%b rdy=%b cnt=%0d want 0 1 1", out_valid, in_ready, blk_cnt);
        end
        // Chain is now 9: F -> B, pad -> 0.
        in_valid = 1'b1; in_data = 4'hF; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        total++;
        if (out_data !== 8'hB0 || out_last !== 1'b1) begin
            bad++; $display("FAIL bp_next: got %h last=%b want b0 last=1", out_data, out_last);
        end
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (blk_cnt !== 8'd2 || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_once: got cnt=%0d rdy=%b want 2 0", blk_cnt, in_ready);
        end
    endtask

    task automatic test_abort();
        logic [3:0] m[$] = '{4'h3, 4'h5};
        logic [7:0] blks[$], cnts[$];
        logic lasts[$];
        bit to;
        pulse_start(4'h2, 4'h6);
        in_valid = 1'b1; in_data = 4'h7; in_last = 1'b0;
        @(negedge clk);
        // start collides with an input handshake in LO; start wins.
        start = 1'b1; key = 4'hB; iv = 4'h9; in_data = 4'hC; in_last = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || blk_cnt !== 8'd0) begin
            bad++; $display("FAIL abort_state: got rdy=%b vld=%b cnt=%0d want 1 0 0", in_ready, out_valid, blk_cnt);
        end
        run_msg(0, 4'hB, 4'h9, m, 0, blks, lasts, cnts, to);
        total++;
        if (to || blks.size() != 1 || blks[0] !== 8'h29 || lasts[0] !== 1'b1) begin
            bad++; $display("FAIL abort_restart: got n=%0d blk=%p want 29 last=1", blks.size(), blks);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(4'hB, 4'h9);
        in_valid = 1'b1; in_data = 4'h3; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_last !== 1'b0 || blk_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid: got rdy=%b vld=%b data=%h last=%b cnt=%0d want all 0",
                     in_ready, out_valid, out_data, out_last, blk_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 4'h5;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got rdy=%b vld=%b want 0 0", in_ready, out_valid);
        end
        // Partial nibble before reset must not leak into the next message.
        check_msg("post_reset", 4'hB, 4'h9, '{4'h3, 4'h5}, 0);
    endtask

    task automatic test_random();
        logic [3:0] m[$];
        int len;
        for (int t = 0; t < 12; t++) begin
            m = {};
            len = 1 + $urandom_range(9);
            for (int i = 0; i < len; i++) m.push_back(4'($urandom_range(15)));
            check_msg($sformatf("rnd%0d", t), 4'($urandom_range(15)), 4'($urandom_range(15)), m, 40);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] m[$];
        // 257 blocks: blk_cnt wraps 255 -> 0 and ends at 1.
        for (int i = 0; i < 514; i++) m.push_back(4'($urandom_range(15)));
        check_msg("wrap", 4'($urandom_range(15)), 4'($urandom_range(15)), m, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        key = 4'h0; iv = 4'h0; in_data = 4'h0;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
